// File: rtl/uart_fifo_if.sv
// Host-side byte interface of the buffered UART: TX push port and RX
// first-word-fall-through pop port.
interface uart_fifo_if;
  logic [7:0] data_in;
  logic       data_in_sync;
  logic       data_out_sync;
  logic [7:0] data_out;
  logic       full_out;
  logic       valid_out;
  logic       full_in;

  modport master (
    output data_in, data_in_sync, data_out_sync,
    input  data_out, full_out, valid_out, full_in
  );

  modport slave (
    input  data_in, data_in_sync, data_out_sync,
    output data_out, full_out, valid_out, full_in
  );
endinterface

// File: rtl/uart_fifo_top.sv
// Buffered full-duplex 8N1 UART: a TX FIFO feeding a serialiser and a
// deserialiser feeding an RX FIFO.
module uart_fifo_top #(
  parameter int unsigned RX_BUFFER_SIZE = 8,
  parameter int unsigned TX_BUFFER_SIZE = 8,
  parameter int unsigned CLK_FRQ        = 12_000_000,
  parameter int unsigned UART_BOUAD     = 115_200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx,
  output logic        tx,
  uart_fifo_if.slave  host
);

  localparam int unsigned BitCyc = CLK_FRQ / UART_BOUAD;
  localparam int unsigned CntW   = $clog2(BitCyc + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCyc - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BitCyc / 2 - 1);

  localparam int unsigned TxAw = $clog2(TX_BUFFER_SIZE);
  localparam int unsigned TxCw = $clog2(TX_BUFFER_SIZE + 1);
  localparam int unsigned RxAw = $clog2(RX_BUFFER_SIZE);
  localparam int unsigned RxCw = $clog2(RX_BUFFER_SIZE + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]      txf_mem_q [TX_BUFFER_SIZE];
  logic [TxAw-1:0] txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
  logic [TxCw-1:0] txf_cnt_q, txf_cnt_d;
  logic            txf_valid_q, txf_full_q;
  logic            txf_push, txf_pop;
  logic [7:0]      txf_head;
  logic            tx_fire_q;
  logic            tx_busy;

  assign txf_push = host.data_in_sync & ~txf_full_q;
  assign txf_pop  = tx_fire_q & txf_valid_q;
  assign txf_head = txf_mem_q[txf_rd_q];

  always_comb begin
    txf_wr_d  = txf_wr_q;
    txf_rd_d  = txf_rd_q;
    txf_cnt_d = txf_cnt_q;
    if (txf_push) txf_wr_d = (txf_wr_q == TxAw'(TX_BUFFER_SIZE - 1)) ? '0 : txf_wr_q + TxAw'(1);
    if (txf_pop)  txf_rd_d = (txf_rd_q == TxAw'(TX_BUFFER_SIZE - 1)) ? '0 : txf_rd_q + TxAw'(1);
    unique case ({txf_push, txf_pop})
      2'b10:   txf_cnt_d = txf_cnt_q + TxCw'(1);
      2'b01:   txf_cnt_d = txf_cnt_q - TxCw'(1);
      default: txf_cnt_d = txf_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < TX_BUFFER_SIZE; i++) txf_mem_q[i] <= '0;
      txf_wr_q    <= '0;
      txf_rd_q    <= '0;
      txf_cnt_q   <= '0;
      txf_valid_q <= 1'b0;
      txf_full_q  <= 1'b0;
    end else begin
      if (txf_push) txf_mem_q[txf_wr_q] <= host.data_in;
      txf_wr_q    <= txf_wr_d;
      txf_rd_q    <= txf_rd_d;
      txf_cnt_q   <= txf_cnt_d;
      txf_valid_q <= (txf_cnt_d != '0);
      txf_full_q  <= (txf_cnt_d == TxCw'(TX_BUFFER_SIZE));
    end
  end

  // ---------------------------------------------------------- TX controller
  // tx_fire_q is both the send strobe and the FIFO pop; it blocks itself so
  // only one byte is in flight while busy has not yet risen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tx_fire_q <= 1'b0;
    else        tx_fire_q <= txf_valid_q & ~tx_busy & ~tx_fire_q;
  end

  // -------------------------------------------------------------- UART TX
  uart_state_e     tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;

  assign tx_busy = (tx_state_q != StIdle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      StIdle: begin
        if (tx_fire_q) begin
          tx_state_d = StStart;
          tx_cnt_d   = '0;
          tx_shift_d = txf_head;
        end
      end
      StStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = StData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = StStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tx_cnt_q == BitLast) tx_state_d = StIdle;
        else                     tx_cnt_d   = tx_cnt_q + CntW'(1);
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (tx_state_q == StStart)     tx = 1'b0;
    else if (tx_state_q == StData) tx = tx_shift_q[0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // -------------------------------------------------------------- UART RX
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e     rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_ready_q, rx_ready_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ready_d = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        // Half-bit recheck rejects glitches and centres later samples.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_state_d = StIdle;
          rx_ready_d = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // ---------------------------------------------------- RX controller/FIFO
  logic            rxc_push_q;
  logic [7:0]      rxc_byte_q;
  logic [7:0]      rxf_mem_q [RX_BUFFER_SIZE];
  logic [RxAw-1:0] rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
  logic [RxCw-1:0] rxf_cnt_q, rxf_cnt_d;
  logic            rxf_valid_q, rxf_full_q;
  logic            rxf_push, rxf_pop;

  assign rxf_push = rxc_push_q & ~rxf_full_q;
  assign rxf_pop  = host.data_out_sync & rxf_valid_q;

  always_comb begin
    rxf_wr_d  = rxf_wr_q;
    rxf_rd_d  = rxf_rd_q;
    rxf_cnt_d = rxf_cnt_q;
    if (rxf_push) rxf_wr_d = (rxf_wr_q == RxAw'(RX_BUFFER_SIZE - 1)) ? '0 : rxf_wr_q + RxAw'(1);
    if (rxf_pop)  rxf_rd_d = (rxf_rd_q == RxAw'(RX_BUFFER_SIZE - 1)) ? '0 : rxf_rd_q + RxAw'(1);
    unique case ({rxf_push, rxf_pop})
      2'b10:   rxf_cnt_d = rxf_cnt_q + RxCw'(1);
      2'b01:   rxf_cnt_d = rxf_cnt_q - RxCw'(1);
      default: rxf_cnt_d = rxf_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxc_push_q  <= 1'b0;
      rxc_byte_q  <= '0;
      for (int unsigned i = 0; i < RX_BUFFER_SIZE; i++) rxf_mem_q[i] <= '0;
      rxf_wr_q    <= '0;
      rxf_rd_q    <= '0;
      rxf_cnt_q   <= '0;
      rxf_valid_q <= 1'b0;
      rxf_full_q  <= 1'b0;
    end else begin
      rxc_push_q  <= rx_ready_q;
      rxc_byte_q  <= rx_shift_q;
      if (rxf_push) rxf_mem_q[rxf_wr_q] <= rxc_byte_q;
      rxf_wr_q    <= rxf_wr_d;
      rxf_rd_q    <= rxf_rd_d;
      rxf_cnt_q   <= rxf_cnt_d;
      rxf_valid_q <= (rxf_cnt_d != '0);
      rxf_full_q  <= (rxf_cnt_d == RxCw'(RX_BUFFER_SIZE));
    end
  end

  assign host.data_out  = rxf_mem_q[rxf_rd_q];
  assign host.valid_out = rxf_valid_q;
  assign host.full_out  = rxf_full_q;
  assign host.full_in   = txf_full_q;

endmodule

// File: tb/tb_uart_fifo_top.sv
// Directed/randomised bench for uart_fifo_top: an independent 8N1 line
// decoder on tx plus byte queues modelling both FIFOs.
module tb_uart_fifo_top;
  localparam int unsigned BitCyc = 104;
  localparam int unsigned Depth  = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_fifo_if bus ();

  uart_fifo_top #(
    .RX_BUFFER_SIZE (Depth),
    .TX_BUFFER_SIZE (Depth),
    .CLK_FRQ        (12_000_000),
    .UART_BOUAD     (115_200)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx),
    .tx    (tx),
    .host  (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line decoder on tx: samples each bit at its centre, measures idle gaps.
  longint     cyc = 0;
  logic [7:0] tx_got[$];
  int         tx_bad = 0;
  longint     last_end = 0;
  bit         prev_valid = 1'b0;
  int         max_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic [9:0] fr;
    longint     n0;
    forever begin
      @(negedge clk);
      if (n_rst && tx === 1'b0) begin
        n0 = cyc;
        if (prev_valid && int'(n0 - last_end) > max_gap) max_gap = int'(n0 - last_end);
        repeat (BitCyc / 2) @(negedge clk);
        fr[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (BitCyc) @(negedge clk);
          fr[i] = tx;
        end
        if (fr[0] !== 1'b0 || fr[9] !== 1'b1) tx_bad++;
        else tx_got.push_back(fr[8:1]);
        repeat (BitCyc / 2 - 1) @(negedge clk);
        last_end   = n0 + 10 * BitCyc;
        prev_valid = 1'b1;
      end
    end
  end

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(BitCyc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BitCyc);
    end
    rx = stop;
    step(BitCyc);
    rx = 1'b1;
    step(4);
  endtask

  task automatic pop_and_check(input string tag, input logic [7:0] exp);
    check(tag, bus.data_out, exp);
    bus.data_out_sync = 1'b1;
    step(1);
    bus.data_out_sync = 1'b0;
  endtask

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [9:0] a5f;
  int         n, mism, lows, tx_occ;
  logic [7:0] b;

  initial begin
    bus.data_in       = '0;
    bus.data_in_sync  = 1'b0;
    bus.data_out_sync = 1'b0;

    // Reset values
    step(3);
    check("rst_tx", tx, 1'b1);
    check("rst_valid_out", bus.valid_out, 1'b0);
    check("rst_full_in", bus.full_in, 1'b0);
    check("rst_full_out", bus.full_out, 1'b0);
    check("rst_data_out", bus.data_out, 8'h00);
    n_rst = 1'b1;
    step(5);

    // Single byte A5: start latency and exact line waveform
    a5f = {1'b1, 8'hA5, 1'b0};
    bus.data_in = 8'hA5;
    bus.data_in_sync = 1'b1;
    step(1);
    bus.data_in_sync = 1'b0;
    check("a5_full_in", bus.full_in, 1'b0);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    check("a5_start_latency_le3", (n <= 3), 1'b1);
    mism = 0;
    for (int k = 0; k < 10 * BitCyc; k++) begin
      if (tx !== a5f[k / BitCyc]) mism++;
      if (bus.full_in !== 1'b0) mism++;
      step(1);
    end
    check("a5_waveform_mismatches", mism, 0);
    step(20);
    check("a5_frames", tx_got.size(), 1);
    if (tx_got.size() > 0) check("a5_byte", tx_got.pop_front(), 8'hA5);

    // Single RX frame 3C
    drive_frame(8'h3C, 1'b1);
    check("rx3c_valid", bus.valid_out, 1'b1);
    pop_and_check("rx3c_data", 8'h3C);
    check("rx3c_valid_after_pop", bus.valid_out, 1'b0);

    // TX burst of 10 back-to-back pushes; FIFO fills, 10th push dropped
    tx_got.delete();
    tx_exp.delete();
    prev_valid = 1'b0;
    max_gap = 0;
    tx_occ = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) tx_occ--;  // transmitter has taken the first byte by now
      if (tx_occ < Depth) begin
        tx_exp.push_back(8'(i));
        tx_occ++;
      end
      bus.data_in = 8'(i);
      bus.data_in_sync = 1'b1;
      step(1);
      check($sformatf("burst_full_in_%0d", i), bus.full_in, (tx_occ == Depth));
    end
    bus.data_in_sync = 1'b0;
    step(9 * (10 * BitCyc + 3) + 50);
    check("burst_frames", tx_got.size(), tx_exp.size());
    while (tx_exp.size() > 0 && tx_got.size() > 0)
      check("burst_byte", tx_got.pop_front(), tx_exp.pop_front());
    check("burst_max_gap_le3", (max_gap <= 3), 1'b1);
    check("burst_bad_frames", tx_bad, 0);
    check("burst_full_in_drained", bus.full_in, 1'b0);

    // RX overflow: 9 random frames, no popping
    rx_exp.delete();
    for (int j = 0; j < 9; j++) begin
      b = 8'($urandom);
      drive_frame(b, 1'b1);
      if (rx_exp.size() < Depth) rx_exp.push_back(b);
      check($sformatf("ovf_full_out_%0d", j), bus.full_out, (rx_exp.size() == Depth));
    end
    check("ovf_valid", bus.valid_out, 1'b1);
    for (int j = 0; j < Depth; j++) begin
      pop_and_check($sformatf("ovf_data_%0d", j), rx_exp.pop_front());
      if (j == 0) check("ovf_full_after_pop", bus.full_out, 1'b0);
    end
    check("ovf_valid_empty", bus.valid_out, 1'b0);

    // Glitch, then a framing error: nothing may be queued
    rx = 1'b0;
    step(20);
    rx = 1'b1;
    step(200);
    drive_frame(8'($urandom), 1'b0);
    step(300);
    check("bad_rx_valid", bus.valid_out, 1'b0);

    // Full duplex with random data
    tx_got.delete();
    for (int j = 0; j < 4; j++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      bus.data_in = b;
      bus.data_in_sync = 1'b1;
      step(1);
      bus.data_in_sync = 1'b0;
      step(1);
    end
    for (int j = 0; j < 4; j++) begin
      b = 8'($urandom);
      rx_exp.push_back(b);
      drive_frame(b, 1'b1);
    end
    step(4 * (10 * BitCyc + 3));
    check("dup_tx_frames", tx_got.size(), 4);
    while (tx_exp.size() > 0 && tx_got.size() > 0)
      check("dup_tx_byte", tx_got.pop_front(), tx_exp.pop_front());
    for (int j = 0; j < 4; j++) pop_and_check($sformatf("dup_rx_%0d", j), rx_exp.pop_front());
    check("dup_rx_empty", bus.valid_out, 1'b0);

    // Asynchronous reset mid-frame discards everything
    drive_frame(8'h5A, 1'b1);
    bus.data_in = 8'h11;
    bus.data_in_sync = 1'b1;
    step(1);
    bus.data_in = 8'h22;
    step(1);
    bus.data_in_sync = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    check("rst_mid_started", tx, 1'b0);
    step(300);
    n_rst = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_valid_out", bus.valid_out, 1'b0);
    check("rst_mid_data_out", bus.data_out, 8'h00);
    step(2);
    n_rst = 1'b1;
    lows = 0;
    for (int k = 0; k < 2500; k++) begin
      if (tx !== 1'b1) lows++;
      step(1);
    end
    check("rst_mid_no_more_frames", lows, 0);
    check("rst_mid_full_in", bus.full_in, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
